// File: rtl/signal_conflict_monitor_pkg.sv
// Shared types and constants for the signal conflict monitor: FSM states,
// fault codes, the all-red lamp pattern and a lowest-index helper.
package mon_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        PASS   = 2'd1,
        FLASH  = 2'd2
    } mon_state_e;

    localparam logic [2:0] FLT_NONE      = 3'd0;
    localparam logic [2:0] FLT_CONFLICT  = 3'd1;
    localparam logic [2:0] FLT_INVALID   = 3'd2;
    localparam logic [2:0] FLT_SKIP      = 3'd3;
    localparam logic [2:0] FLT_SHORT_YEL = 3'd4;
    localparam logic [2:0] FLT_TIMEOUT   = 3'd5;
    localparam logic [2:0] FLT_STUCK     = 3'd6;

    localparam logic [3:0] ALL_RED_PAT = 4'hF;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/signal_conflict_monitor_if.sv
// Lamp-drive bus between the traffic-light controller, the conflict monitor
// and the lamp drivers. The controller side is master, the monitor is slave.
interface signal_conflict_monitor_if;

    logic [3:0] red_in;
    logic [3:0] yel_in;
    logic [3:0] grn_in;
    logic       fault_clr;

    logic [3:0] red_out;
    logic [3:0] yel_out;
    logic [3:0] grn_out;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_appr;

    modport master (
        output red_in, yel_in, grn_in, fault_clr,
        input  red_out, yel_out, grn_out, fault, fault_code, fault_appr
    );

    modport slave (
        input  red_in, yel_in, grn_in, fault_clr,
        output red_out, yel_out, grn_out, fault, fault_code, fault_appr
    );

endinterface

// File: rtl/signal_conflict_monitor_lamp_timer.sv
// Per-approach lamp timer: tracks yellow (and, with MON_TIMEOUT_EN, green)
// run lengths and flags skip, short-yellow and green-timeout for one approach.
module lamp_timer
    import mon_pkg::*;
#(
    parameter int MAX_GREEN = 16,
    parameter int MIN_YEL   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cur_red,
    input  logic cur_yel,
    input  logic cur_grn,
    input  logic prev_yel,
    input  logic prev_grn,
    output logic skip,
    output logic short_yel,
    output logic timeout
);

    localparam int YW = $clog2(MIN_YEL + 2);
    localparam logic [YW-1:0] YEL_SAT = YW'(MIN_YEL + 1);

    logic [YW-1:0] yel_cnt_q, yel_cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        yel_cnt_d = '0;
        if (!clr && cur_yel) begin
            yel_cnt_d = (yel_cnt_q == YEL_SAT) ? yel_cnt_q : yel_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all flops see pre-edge values.
        if (rst) begin
            yel_cnt_q <= '0;
        end else begin
            yel_cnt_q <= yel_cnt_d;
        end
    end

    assign skip      = prev_grn & cur_red;
    assign short_yel = prev_yel & ~cur_yel & (yel_cnt_q < YW'(MIN_YEL));

`ifdef MON_TIMEOUT_EN
    localparam int GW = $clog2(MAX_GREEN + 2);
    localparam logic [GW-1:0] GRN_SAT = GW'(MAX_GREEN + 1);

    logic [GW-1:0] grn_cnt_q, grn_cnt_d;

    always_comb begin
        grn_cnt_d = '0;
        if (!clr && cur_grn) begin
            grn_cnt_d = (grn_cnt_q == GRN_SAT) ? grn_cnt_q : grn_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grn_cnt_q <= '0;
        end else begin
            grn_cnt_q <= grn_cnt_d;
        end
    end

    // grn_cnt_q counts greens up to the previous sample, so this is green number MAX_GREEN+1.
    assign timeout = cur_grn & (grn_cnt_q >= GW'(MAX_GREEN));
`else
    logic [32:0] unused_cfg;
    assign unused_cfg = {cur_grn, 32'(MAX_GREEN)};
    assign timeout    = 1'b0;
`endif

endmodule

// File: rtl/signal_conflict_monitor.sv
// Signal conflict monitor: passes the 12 lamp drives with one cycle of latency
// and forces flashing red on a safety fault. MON_TIMEOUT_EN adds codes 5 and 6.
module signal_conflict_monitor
    import mon_pkg::*;
#(
    parameter int MAX_GREEN   = 16,
    parameter int MIN_YEL     = 1,
    parameter int ALL_RED     = 4,
    parameter int FLASH_HALF  = 8,
    parameter int STUCK_LIMIT = 64
) (
    input logic clk,
    input logic rst,
    signal_conflict_monitor_if.slave bus
);

    localparam int CW = $clog2(ALL_RED + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    mon_state_e    state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic [3:0]    red_q, red_d, yel_q, yel_d, grn_q, grn_d;
    logic [3:0]    prev_red_q, prev_red_d, prev_yel_q, prev_yel_d, prev_grn_q, prev_grn_d;
    logic [2:0]    code_q, code_d;
    logic [1:0]    appr_q, appr_d;

    logic [3:0] invalid_v, skip_v, short_v, timeout_v;
    logic       conflict, stuck, counters_clr;
    logic [2:0] det_code;
    logic [1:0] det_appr;

    for (genvar i = 0; i < 4; i++) begin : g_timer
        lamp_timer #(
            .MAX_GREEN (MAX_GREEN),
            .MIN_YEL   (MIN_YEL)
        ) u_timer (
            .clk       (clk),
            .rst       (rst),
            .clr       (counters_clr),
            .cur_red   (bus.red_in[i]),
            .cur_yel   (bus.yel_in[i]),
            .cur_grn   (bus.grn_in[i]),
            .prev_yel  (prev_yel_q[i]),
            .prev_grn  (prev_grn_q[i]),
            .skip      (skip_v[i]),
            .short_yel (short_v[i]),
            .timeout   (timeout_v[i])
        );
    end

`ifdef MON_TIMEOUT_EN
    localparam int SW = $clog2(STUCK_LIMIT + 2);
    localparam logic [SW-1:0] STUCK_SAT = SW'(STUCK_LIMIT + 1);

    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic          same;

    always_comb begin
        same        = ({bus.red_in, bus.yel_in, bus.grn_in} == {prev_red_q, prev_yel_q, prev_grn_q});
        stuck_cnt_d = '0;
        if (!counters_clr && same) begin
            stuck_cnt_d = (stuck_cnt_q == STUCK_SAT) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
        end
        stuck = same && (stuck_cnt_q >= SW'(STUCK_LIMIT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_cnt_q <= '0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
        end
    end
`else
    logic [31:0] unused_stuck_limit;
    assign unused_stuck_limit = 32'(STUCK_LIMIT);
    assign stuck              = 1'b0;
`endif

    // Fault detection on the live sample; lowest code wins.
    always_comb begin
        invalid_v = '0;
        conflict  = ($countones(bus.grn_in) > 1);
        for (int i = 0; i < 4; i++) begin
            invalid_v[i] = ($countones({bus.red_in[i], bus.yel_in[i], bus.grn_in[i]}) != 1);
        end
        det_code = FLT_NONE;
        det_appr = 2'd0;
        if (conflict) begin
            det_code = FLT_CONFLICT;
        end else if (|invalid_v) begin
            det_code = FLT_INVALID;
            det_appr = lowest_idx(invalid_v);
        end else if (|skip_v) begin
            det_code = FLT_SKIP;
            det_appr = lowest_idx(skip_v);
        end else if (|short_v) begin
            det_code = FLT_SHORT_YEL;
            det_appr = lowest_idx(short_v);
        end else if (|timeout_v) begin
            det_code = FLT_TIMEOUT;
            det_appr = lowest_idx(timeout_v);
        end else if (stuck) begin
            det_code = FLT_STUCK;
        end
    end

    always_comb begin
        prev_red_d = bus.red_in;
        prev_yel_d = bus.yel_in;
        prev_grn_d = bus.grn_in;
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        flash_cnt_d  = flash_cnt_q;
        code_d       = code_q;
        appr_d       = appr_q;
        red_d        = ALL_RED_PAT;
        yel_d        = '0;
        grn_d        = '0;
        counters_clr = 1'b0;
        unique case (state_q)
            ALLRED, PASS: begin
                if (det_code != FLT_NONE) begin
                    state_d     = FLASH;
                    flash_cnt_d = '0;
                    code_d      = det_code;
                    appr_d      = det_appr;
                end else if (state_q == PASS || clr_cnt_q == CW'(ALL_RED - 1)) begin
                    state_d = PASS;
                    red_d   = bus.red_in;
                    yel_d   = bus.yel_in;
                    grn_d   = bus.grn_in;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            FLASH: begin
                // A clear is only honoured when the sample itself is lamp-safe.
                if (bus.fault_clr && det_code != FLT_CONFLICT && det_code != FLT_INVALID) begin
                    state_d      = ALLRED;
                    clr_cnt_d    = '0;
                    code_d       = FLT_NONE;
                    appr_d       = 2'd0;
                    counters_clr = 1'b1;
                end else if (flash_cnt_q == FW'(FLASH_HALF - 1)) begin
                    flash_cnt_d = '0;
                    red_d       = ~red_q;
                end else begin
                    flash_cnt_d = flash_cnt_q + 1'b1;
                    red_d       = red_q;
                end
            end
            default: state_d = ALLRED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ALLRED;
            clr_cnt_q   <= '0;
            flash_cnt_q <= '0;
            red_q       <= ALL_RED_PAT;
            yel_q       <= '0;
            grn_q       <= '0;
            code_q      <= FLT_NONE;
            appr_q      <= 2'd0;
            prev_red_q  <= ALL_RED_PAT;
            prev_yel_q  <= '0;
            prev_grn_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            red_q       <= red_d;
            yel_q       <= yel_d;
            grn_q       <= grn_d;
            code_q      <= code_d;
            appr_q      <= appr_d;
            prev_red_q  <= prev_red_d;
            prev_yel_q  <= prev_yel_d;
            prev_grn_q  <= prev_grn_d;
        end
    end

    assign bus.red_out    = red_q;
    assign bus.yel_out    = yel_q;
    assign bus.grn_out    = grn_q;
    assign bus.fault      = (state_q == FLASH);
    assign bus.fault_code = code_q;
    assign bus.fault_appr = appr_q;

endmodule
